// File: rtl/lfsr_ctrl_pkg.sv
// rtl/lfsr_ctrl_pkg.sv - shared state/rate encodings and step period helper for lfsr_step_ctrl
package lfsr_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_BURST  = 2'd2,
    ST_SINGLE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    RATE_1HZ = 2'd0,
    RATE_2HZ = 2'd1,
    RATE_4HZ = 2'd2,
    RATE_8HZ = 2'd3
  } rate_t;

  // Each rate step halves the period, so the terminal count is a plain shift of the clock rate.
  function automatic logic [31:0] calc_tc(input int clk_hz, input logic [1:0] rate);
    return 32'(clk_hz >> rate) - 32'd1;
  endfunction

endpackage

// File: rtl/lfsr_step_ctrl_if.sv
// rtl/lfsr_step_ctrl_if.sv - request/status bundle between board I/O and the step controller
interface lfsr_step_ctrl_if;
  logic       run_req;
  logic       step_req;
  logic       burst_req;
  logic [1:0] rate_sel;
  logic [7:0] burst_len;
  logic       step_en;
  logic       busy;
  logic [1:0] mode;
  logic [7:0] steps_left;

  modport master (
    output run_req, step_req, burst_req, rate_sel, burst_len,
    input  step_en, busy, mode, steps_left
  );

  modport slave (
    input  run_req, step_req, burst_req, rate_sel, burst_len,
    output step_en, busy, mode, steps_left
  );
endinterface

// File: rtl/rate_divider.sv
// rtl/rate_divider.sv - step period counter with clear, programmable terminal count and wrap pulse
module rate_divider #(
  parameter int W = 27
) (
  input  logic         CCLK,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] tc,
  output logic         wrap
);
  logic [W-1:0] cnt;

  // A clear in the same cycle suppresses the wrap, so a stop request beats a due step.
  assign wrap = en && !clr && (cnt == tc);

  always_ff @(posedge CCLK or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + W'(1);
    end
  end
endmodule

// File: rtl/lfsr_step_ctrl.sv
// rtl/lfsr_step_ctrl.sv - LFSR step sequencer (run / burst / single) producing step enables on CCLK
// Optional LFSR_CTRL_INPUT_SYNC_EN: requests are raw button levels, synchronized and edge-detected.
module lfsr_step_ctrl
  import lfsr_ctrl_pkg::*;
#(
  parameter int CLK_HZ    = 100000000,
  parameter int DIV_WIDTH = 27
) (
  input logic             CCLK,
  input logic             rst,
  lfsr_step_ctrl_if.slave bus
);
  state_t               mode_q;
  rate_t                rate_reg;
  logic                 step_en_q;
  logic [7:0]           steps_left_q;
  logic                 run_p;
  logic                 step_p;
  logic                 burst_p;
  logic                 cnt_en;
  logic                 cnt_clr;
  logic                 wrap;
  logic [DIV_WIDTH-1:0] tc;

`ifdef LFSR_CTRL_INPUT_SYNC_EN
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] sync3;
  logic [2:0] req_q;

  always_ff @(posedge CCLK or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
      req_q <= '0;
    end else begin
      sync1 <= {bus.run_req, bus.burst_req, bus.step_req};
      sync2 <= sync1;
      sync3 <= sync2;
      req_q <= sync2 & ~sync3;
    end
  end

  assign {run_p, burst_p, step_p} = req_q;
`else
  assign run_p   = bus.run_req;
  assign burst_p = bus.burst_req;
  assign step_p  = bus.step_req;
`endif

  assign tc      = DIV_WIDTH'(calc_tc(CLK_HZ, rate_reg));
  assign cnt_en  = (mode_q == ST_RUN) || (mode_q == ST_BURST);
  assign cnt_clr = !cnt_en || run_p;

  rate_divider #(.W(DIV_WIDTH)) u_div (
    .CCLK (CCLK),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .tc   (tc),
    .wrap (wrap)
  );

  always_ff @(posedge CCLK or posedge rst) begin
    if (rst) begin
      mode_q       <= ST_IDLE;
      rate_reg     <= RATE_1HZ;
      step_en_q    <= 1'b0;
      steps_left_q <= '0;
    end else begin
      step_en_q <= 1'b0;
      case (mode_q)
        ST_IDLE: begin
          if (run_p) begin
            mode_q   <= ST_RUN;
            rate_reg <= rate_t'(bus.rate_sel);
          end else if (burst_p && bus.burst_len != 8'd0) begin
            mode_q       <= ST_BURST;
            rate_reg     <= rate_t'(bus.rate_sel);
            steps_left_q <= bus.burst_len;
          end else if (step_p) begin
            mode_q <= ST_SINGLE;
          end
        end
        ST_RUN: begin
          if (run_p) begin
            mode_q <= ST_IDLE;
          end else if (wrap) begin
            step_en_q <= 1'b1;
            rate_reg  <= rate_t'(bus.rate_sel);
          end
        end
        ST_BURST: begin
          if (run_p) begin
            mode_q       <= ST_IDLE;
            steps_left_q <= '0;
          end else if (wrap) begin
            step_en_q    <= 1'b1;
            rate_reg     <= rate_t'(bus.rate_sel);
            steps_left_q <= steps_left_q - 8'd1;
            if (steps_left_q == 8'd1) begin
              mode_q <= ST_IDLE;
            end
          end
        end
        ST_SINGLE: begin
          step_en_q <= 1'b1;
          mode_q    <= ST_IDLE;
        end
        default: mode_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.step_en    = step_en_q;
  assign bus.busy       = (mode_q != ST_IDLE);
  assign bus.mode       = mode_q;
  assign bus.steps_left = steps_left_q;
endmodule

// File: tb/tb_lfsr_step_ctrl.sv
// tb/tb_lfsr_step_ctrl.sv - scoreboard bench for lfsr_step_ctrl at CLK_HZ=16
module tb_lfsr_step_ctrl;
  localparam int HZ = 16;
`ifdef LFSR_CTRL_INPUT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 0;
`endif

  typedef struct {
    int t;
    int sl;
    int md;
  } exp_t;

  logic CCLK = 1'b0;
  logic rst  = 1'b1;
  int   ncyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  lfsr_step_ctrl_if bus ();

  lfsr_step_ctrl #(.CLK_HZ(HZ), .DIV_WIDTH(5)) dut (
    .CCLK (CCLK),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 CCLK = ~CCLK;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int period(input int r);
    return HZ >> r;
  endfunction

  task automatic push(input int t, input int sl, input int md);
    exp_t e;
    e.t = t; e.sl = sl; e.md = md;
    exp_q.push_back(e);
  endtask

  // Monitor: ncyc counts rising edges; each step_en seen must match the oldest expectation.
  always @(negedge CCLK) begin
    ncyc++;
    if (bus.step_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_step actual_cycle=%0d required=none", ncyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("step_time", ncyc, mon_e.t);
        chk("step_steps_left", int'(bus.steps_left), mon_e.sl);
        chk("step_mode", int'(bus.mode), mon_e.md);
      end
    end
  end

  task automatic tick_to(input int n);
    int g = 0;
    while (ncyc < n && g < 5000) begin
      @(negedge CCLK); #1;
      g++;
    end
  endtask

  task automatic req(input logic r, input logic b, input logic s, output int acc);
    @(negedge CCLK); #1;
    bus.run_req = r; bus.burst_req = b; bus.step_req = s;
    acc = ncyc + 1 + LAT;
    @(negedge CCLK); #1;
    bus.run_req = 1'b0; bus.burst_req = 1'b0; bus.step_req = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int g = 0;
    while (exp_q.size() != 0 && g < budget) begin
      @(negedge CCLK); #1;
      g++;
    end
    chk({name, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (6) begin @(negedge CCLK); #1; end
  endtask

  task automatic check_idle(input string name);
    chk({name, "_step_en"}, int'(bus.step_en), 0);
    chk({name, "_busy"}, int'(bus.busy), 0);
    chk({name, "_mode"}, int'(bus.mode), 0);
    chk({name, "_steps_left"}, int'(bus.steps_left), 0);
  endtask

  initial begin
    int a, b, r, p, k, n, s, off;
    bus.run_req = 1'b0; bus.step_req = 1'b0; bus.burst_req = 1'b0;
    bus.rate_sel = 2'd0; bus.burst_len = 8'd0;

    repeat (3) @(negedge CCLK);
    #1;
    check_idle("reset");
    rst = 1'b0;
    repeat (2) begin @(negedge CCLK); #1; end

    // Continuous run at random rates, stopped at a random point (possibly exactly on a wrap).
    for (int it = 0; it < 4; it++) begin
      r = $urandom_range(0, 3);
      p = period(r);
      k = $urandom_range(1, 3);
      off = $urandom_range(0, p - 1);
      bus.rate_sel = 2'(r);
      req(1'b1, 1'b0, 1'b0, a);
      s = a + k * p + off;
      if (s < a + 2 + LAT) s = a + 2 + LAT;
      for (int j = 1; a + j * p < s; j++) push(a + j * p, 0, 1);
      tick_to(a);
      chk("run_mode", int'(bus.mode), 1);
      chk("run_busy", int'(bus.busy), 1);
      tick_to(s - 2 - LAT);
      req(1'b1, 1'b0, 1'b0, b);
      tick_to(b);
      chk("run_stop_mode", int'(bus.mode), 0);
      drain("run", 100);
    end

    // Mid-period rate change lands on the next period; requests during RUN are ignored.
    bus.rate_sel = 2'd0;
    bus.burst_len = 8'd4;
    req(1'b1, 1'b0, 1'b0, a);
    push(a + 16, 0, 1); push(a + 18, 0, 1); push(a + 20, 0, 1);
    tick_to(a + 4);
    bus.rate_sel = 2'd3;
    req(1'b0, 1'b1, 1'b1, b);
    tick_to(a + 21 - 2 - LAT);
    req(1'b1, 1'b0, 1'b0, b);
    tick_to(b);
    chk("ratechg_stop_mode", int'(bus.mode), 0);
    drain("ratechg", 60);

    // Random bursts.
    for (int it = 0; it < 5; it++) begin
      r = $urandom_range(0, 3);
      p = period(r);
      n = $urandom_range(1, 6);
      bus.rate_sel = 2'(r);
      bus.burst_len = 8'(n);
      req(1'b0, 1'b1, 1'b0, a);
      for (int j = 1; j <= n; j++) push(a + j * p, n - j, (j == n) ? 0 : 2);
      tick_to(a);
      chk("burst_mode", int'(bus.mode), 2);
      chk("burst_steps_left", int'(bus.steps_left), n);
      drain("burst", 150);
      chk("burst_end_mode", int'(bus.mode), 0);
    end

    // Burst aborted by run_req after two steps.
    bus.rate_sel = 2'd3;
    bus.burst_len = 8'd5;
    req(1'b0, 1'b1, 1'b0, a);
    push(a + 2, 4, 2); push(a + 4, 3, 2);
    tick_to(a + 5 - 2 - LAT);
    req(1'b1, 1'b0, 1'b0, b);
    tick_to(b);
    chk("abort_mode", int'(bus.mode), 0);
    chk("abort_steps_left", int'(bus.steps_left), 0);
    drain("abort", 40);

    // Single step.
    req(1'b0, 1'b0, 1'b1, a);
    push(a + 1, 0, 0);
    tick_to(a);
    chk("single_mode", int'(bus.mode), 3);
    chk("single_busy", int'(bus.busy), 1);
    drain("single", 20);

    // All three requests together: run wins.
    bus.rate_sel = 2'd1;
    bus.burst_len = 8'd4;
    req(1'b1, 1'b1, 1'b1, a);
    push(a + 8, 0, 1);
    tick_to(a);
    chk("prio_mode", int'(bus.mode), 1);
    chk("prio_steps_left", int'(bus.steps_left), 0);
    tick_to(a + 10 - 2 - LAT);
    req(1'b1, 1'b0, 1'b0, b);
    drain("prio", 40);

    // Zero-length burst is ignored.
    bus.burst_len = 8'd0;
    req(1'b0, 1'b1, 1'b0, a);
    tick_to(a);
    chk("zero_burst_mode", int'(bus.mode), 0);
    chk("zero_burst_busy", int'(bus.busy), 0);
    drain("zero_burst", 20);

    // Asynchronous reset while a burst step is being presented.
    bus.rate_sel = 2'd2;
    bus.burst_len = 8'd5;
    req(1'b0, 1'b1, 1'b0, a);
    push(a + 4, 4, 2);
    tick_to(a + 4);
    rst = 1'b1;
    #1;
    check_idle("async_reset");
    exp_q.delete();
    @(negedge CCLK); #1;
    rst = 1'b0;
    drain("post_reset", 20);

`ifdef LFSR_CTRL_INPUT_SYNC_EN
    // A held button yields exactly one request.
    @(negedge CCLK); #1;
    bus.step_req = 1'b1;
    a = ncyc + 1 + LAT;
    push(a + 1, 0, 0);
    repeat (10) begin @(negedge CCLK); #1; end
    bus.step_req = 1'b0;
    drain("held_button", 20);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/lfsr_step_ctrl.md
# lfsr_step_ctrl

Sequencing controller that decides when the LFSR advances, replacing a free-running divided clock with single-cycle step enables on the board clock. It supports continuous run at one of four rates, single-step and N-step bursts, driven by button/switch requests. It sits between the Basys3 board I/O and the LFSR core, which runs on CCLK and advances only when step_en is high.

## Interface
- CLK_HZ, 100000000, CCLK frequency; sets the step period table (must be ≥ 8).
- DIV_WIDTH, 27, period counter width; must hold CLK_HZ-1.
- CCLK  in  1  board clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- run_req  in  1  toggle continuous run (single-cycle pulse).
- step_req  in  1  request one step (pulse).
- burst_req  in  1  request burst of burst_len steps (pulse).
- rate_sel  in  2  step rate: 0=1 Hz, 1=2 Hz, 2=4 Hz, 3=8 Hz.
- burst_len  in  8  burst step count, sampled on accepted burst_req.
- step_en  out  1  one-cycle LFSR advance enable, registered.
- busy  out  1  high when mode ≠ IDLE.
- mode  out  2  current state encoding.
- steps_left  out  8  remaining burst steps.

## Operation
- States: IDLE=0, RUN=1, BURST=2, SINGLE=3.
- Period terminal count TC = (CLK_HZ >> rate_reg) - 1; rate_reg latches rate_sel on entry to RUN/BURST and at every period wrap; mid-period rate_sel changes take effect at next period.
- Period counter: cleared on entry to RUN/BURST; increments each cycle; at TC wraps to 0 and issues a step.
- IDLE: run_req → RUN; else burst_req with burst_len≠0 → BURST, steps_left=burst_len; burst_len=0 ignored; else step_req → SINGLE.
- Same-cycle requests priority: run_req > burst_req > step_req; losers dropped.
- RUN: steps every TC+1 cycles; run_req → IDLE, counter cleared, no step that cycle; step_req/burst_req ignored.
- BURST: steps as RUN; each step decrements steps_left; step that makes steps_left 0 also returns to IDLE; run_req aborts → IDLE, steps_left=0; other requests ignored.
- SINGLE: step_en for exactly one cycle, then IDLE unconditionally; requests in SINGLE ignored.
- Counter/decrement arithmetic unsigned, no saturation needed (states guarantee no underflow).

## Timing
- Reset (async): mode=IDLE, step_en=0, busy=0, steps_left=0, counter=0, rate_reg=0; outputs drop immediately, mid-burst/mid-run state lost, no pending steps.
- Request accepted on edge k (input high before edge k).
- SINGLE: step_en high during cycle after edge k+1 … exactly the cycle following edge k+1; latency 1 cycle after state change, 2 edges from request.
- RUN/BURST: first step_en high TC+1 cycles after acceptance edge; subsequent pulses spaced exactly TC+1 cycles; each pulse exactly 1 cycle wide.
- busy/mode update on the acceptance edge; in BURST, mode returns to IDLE on the same edge that raises the final step_en.
- Stopping RUN on the edge a wrap would occur: stop wins, no step_en.

## Configuration
- LFSR_CTRL_INPUT_SYNC_EN defined: run_req/step_req/burst_req are raw button levels; each passes a 2-flop synchronizer plus rising-edge detector, adding 3 cycles latency; holding a button yields one request.
- Undefined: inputs are already synchronous single-cycle pulses, used directly; a held level re-requests every cycle.

## Structure
- Package lfsr_ctrl_pkg: state encoding constants, rate_sel encoding, TC computation function.
- Sub-module rate_divider: period counter with clear, programmable TC, wrap pulse out; controller FSM, rate latch and burst counter stay in top.
- Sync/edge-detect logic inside the `ifdef` block of the top.

## Test plan
- Sim CLK_HZ=16, macro off. Reset mid-RUN → step_en, busy, mode, steps_left all 0 immediately.
- rate_sel=0, run_req pulse → first step_en 16 cycles later, then every 16; second run_req → no further pulses, mode=0.
- rate_sel=3, burst_len=3, burst_req → exactly 3 pulses spaced 2 cycles, steps_left 3→2→1→0, mode=0 on final pulse edge.
- step_req in IDLE → one step_en 1 cycle after mode=3; step_req during RUN → no extra pulse.
- run_req+burst_req+step_req same cycle → mode=RUN; burst_req with burst_len=0 → stays IDLE.
- Macro on: 10-cycle held step button → exactly one step_en, 3 cycles later than macro-off case.
